wts_channel_volume_mix: RTL and testbench
=========================================

Name: wts_channel_volume_mix

Overview:
- Parametrised successor to the single-channel volume stage.
- Time-multiplexed volume/envelope scaler for NUM_CH wave-table channels, with per-channel click-free volume ramping and noise substitution.
- Includes a saturating frame mixer.
- Sits between the per-channel SRAM sample fetch and the DAC/output filter; one shared multiplier pipeline serves all channels.

Parameters:
- NUM_CH, 5, number of channels; channel index width CH_W = max(1, clog2(NUM_CH)).
- SAMPLE_W, 8, signed sample width of in_sample and out_channel.
- VOL_W, 4, unsigned volume register width.
- ENV_W, 5, unsigned envelope width.
- MIX_W, 11, signed mixer output width.
- RAMP_DIV, 16, frames per volume ramp step (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- reg_wr  in  1  volume register write strobe
- reg_ch  in  CH_W  channel addressed by reg_wr
- reg_volume  in  VOL_W  target volume written by reg_wr
- in_valid  in  1  sample slot present
- in_ch  in  CH_W  channel of current slot
- in_sample  in  SAMPLE_W  signed wave sample (sram_q)
- in_envelope  in  ENV_W  envelope level for the slot
- in_noise_en  in  1  replace sample with noise
- in_noise  in  1  noise bit
- out_valid  out  1  scaled channel sample valid
- out_ch  out  CH_W  channel of out_channel
- out_channel  out  SAMPLE_W  signed scaled sample
- mix_valid  out  1  one-cycle pulse, frame mix ready
- mix_out  out  MIX_W  signed saturated sum of one frame

Behaviour:
- Reset (async, active-high): target_vol[*], cur_vol[*], ramp counter, accumulator and pipeline registers go to 0. All outputs are 0.
- Register write: reg_wr with reg_ch < NUM_CH sets target_vol[reg_ch] = reg_volume on the next edge. Writes with reg_ch >= NUM_CH are ignored.
- Input slots: an in_valid slot with in_ch >= NUM_CH is dropped; no out_valid results from it. in_valid may be asserted every cycle.
- Frame end: an accepted slot with in_ch == NUM_CH-1.
- Ramp counter: increments at each frame end. At a frame end with counter == RAMP_DIV-1, the counter clears, and every cur_vol steps by 1 toward its target_vol (no change if equal).
  - If a write and a ramp step hit the same channel in the same cycle, the step uses the old target and the write takes effect.
- Stage 1 (capture):
  - Latch ch, envelope and cur_vol[ch].
  - Effective sample is in_sample when in_noise_en=0.
  - Otherwise it is +(2^(SAMPLE_W-1)-1) for in_noise=1, and -(2^(SAMPLE_W-1)-1) for in_noise=0 (symmetric: 127 / -127).
- Stage 2: gain = cur_vol * envelope, unsigned, VOL_W+ENV_W bits (max 465).
- Stage 3: out_channel = (sample * gain) >>> (VOL_W+ENV_W), an arithmetic shift that floors toward -inf. out_valid and out_ch are registered with it.
- Latency: fixed 3 cycles from in_valid to out_valid. Full throughput.
- Mixer:
  - Each out_valid adds sign-extended out_channel to the accumulator.
  - When out_ch == NUM_CH-1: mix_out = sat(acc + out_channel) to MIX_W, mix_valid pulses for 1 cycle, and acc clears in the same cycle.
  - Saturation clamps to [-2^(MIX_W-1), 2^(MIX_W-1)-1] and applies to the running accumulator too.
  - Channels may arrive in any order; missing channels contribute 0.
  - If the last channel never arrives, the accumulator holds.
- Reset mid-frame: the pipeline flushes and partial sums are discarded; no mix_valid is emitted for that frame.

Decomposition:
- Package wts_volume_pkg:
  - CH_W derivation function
  - saturating-resize function
  - noise magnitude constant function of SAMPLE_W
- Sub-module wts_volume_ramp:
  - target_vol/cur_vol register arrays
  - ramp counter and frame-end step logic
  - read port for the stage-1 channel
- The top level holds the 3-stage multiply pipeline and the mixer.

Test Plan:
- Reset then write ch0 vol=15, RAMP_DIV=1. Feed frames with ch0 sample=127, env=31 → cur_vol climbs 0..15 over 15 frames; final out_channel=115 (127*465>>9).
- Sample -128, vol 15, env 31 on ch2 → out_channel=-117 (floor of -116.25), out_valid exactly 3 cycles after in_valid, out_ch=2.
- in_noise_en=1, vol 15, env 31: noise=1 → 115; noise=0 → -116; noise=1 with env 0 → 0.
- All 5 channels at 127/vol15/env31, back-to-back slots ch0..ch4 → one mix_valid pulse with mix_out=575. With MIX_W=9 the same frame → mix_out=255 (saturated).
- RAMP_DIV=16, target 4 from 0 → cur_vol increments only at every 16th frame end. Simultaneous reg_wr on the stepping channel → target updated, one step taken from the old target.
- reg_ch=7 write and in_ch=6 slot → no state change, no out_valid. Assert reset mid-frame → all outputs 0 immediately, no mix_valid afterwards for the partial frame.

Source files
------------

// File: rtl/wts_volume_pkg.sv
// wts_volume_pkg: sizing and arithmetic helpers shared by the channel volume mixer
package wts_volume_pkg;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Clamp v into the signed range of a w-bit value
   function automatic int sat(input int v, input int w);
      int hi;
      int lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction

   // Symmetric noise amplitude so +noise and -noise have equal magnitude
   function automatic int noise_mag(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

endpackage

// File: rtl/wts_volume_ramp.sv
// wts_volume_ramp: per-channel target/current volume with frame-paced click-free ramping
module wts_volume_ramp
   import wts_volume_pkg::*;
#(
   parameter int NUM_CH = 5,
   parameter int VOL_W = 4,
   parameter int RAMP_DIV = 16,
   localparam int CH_W = ch_w(NUM_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_reg_wr,
   input  logic [CH_W-1:0]  i_reg_ch,
   input  logic [VOL_W-1:0] i_reg_volume,
   input  logic             i_frame_end,
   input  logic [CH_W-1:0]  i_rd_ch,
   output logic [VOL_W-1:0] o_rd_vol
);
   localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   logic [VOL_W-1:0] r_target [NUM_CH];
   logic [VOL_W-1:0] r_cur [NUM_CH];
   logic [CNT_W-1:0] r_cnt;
   logic             w_step;

   assign w_step = i_frame_end && (r_cnt == CNT_W'(RAMP_DIV - 1));
   assign o_rd_vol = (int'(i_rd_ch) < NUM_CH) ? r_cur[i_rd_ch] : '0;

   // A step compares against the target as it was before any same-cycle write
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cnt <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_target[i] <= '0;
            r_cur[i] <= '0;
         end
      end else begin
         if (i_frame_end) r_cnt <= w_step ? '0 : r_cnt + CNT_W'(1);
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_step && r_cur[i] < r_target[i]) r_cur[i] <= r_cur[i] + VOL_W'(1);
            else if (w_step && r_cur[i] > r_target[i]) r_cur[i] <= r_cur[i] - VOL_W'(1);
            if (i_reg_wr && int'(i_reg_ch) == i) r_target[i] <= i_reg_volume;
         end
      end

endmodule

// File: rtl/wts_channel_volume_mix.sv
// wts_channel_volume_mix: shared 3-stage volume/envelope scaler for all wave-table channels
// plus a saturating per-frame mixer
module wts_channel_volume_mix
   import wts_volume_pkg::*;
#(
   parameter int NUM_CH = 5,
   parameter int SAMPLE_W = 8,
   parameter int VOL_W = 4,
   parameter int ENV_W = 5,
   parameter int MIX_W = 11,
   parameter int RAMP_DIV = 16,
   localparam int CH_W = ch_w(NUM_CH)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       reg_wr,
   input  logic [CH_W-1:0]            reg_ch,
   input  logic [VOL_W-1:0]           reg_volume,
   input  logic                       in_valid,
   input  logic [CH_W-1:0]            in_ch,
   input  logic signed [SAMPLE_W-1:0] in_sample,
   input  logic [ENV_W-1:0]           in_envelope,
   input  logic                       in_noise_en,
   input  logic                       in_noise,
   output logic                       out_valid,
   output logic [CH_W-1:0]            out_ch,
   output logic signed [SAMPLE_W-1:0] out_channel,
   output logic                       mix_valid,
   output logic signed [MIX_W-1:0]    mix_out
);
   localparam int GAIN_W = VOL_W + ENV_W;
   localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic signed [SAMPLE_W-1:0] NOISE_POS = SAMPLE_W'(noise_mag(SAMPLE_W));
   localparam logic signed [SAMPLE_W-1:0] NOISE_NEG = -NOISE_POS;

   logic                       w_accept;
   logic                       w_frame_end;
   logic [VOL_W-1:0]           w_vol;
   logic signed [SAMPLE_W-1:0] w_sample;
   logic signed [PROD_W-1:0]   w_prod;
   logic signed [31:0]         w_sum;
   logic signed [MIX_W-1:0]    w_sat;
   logic                       r1_valid, r2_valid, r3_valid;
   logic [CH_W-1:0]            r1_ch, r2_ch, r3_ch;
   logic [ENV_W-1:0]           r1_env;
   logic [VOL_W-1:0]           r1_vol;
   logic signed [SAMPLE_W-1:0] r1_sample, r2_sample, r3_out;
   logic [GAIN_W-1:0]          r2_gain;
   logic signed [MIX_W-1:0]    r_acc, r_mix_out;
   logic                       r_mix_valid;

   assign w_accept = in_valid && (int'(in_ch) < NUM_CH);
   assign w_frame_end = w_accept && (in_ch == LAST_CH);
   assign w_sample = !in_noise_en ? in_sample : in_noise ? NOISE_POS : NOISE_NEG;
   assign w_prod = PROD_W'(r2_sample) * $signed({1'b0, r2_gain});
   assign w_sum = 32'(r_acc) + 32'(r3_out);
   assign w_sat = MIX_W'(sat(w_sum, MIX_W));

   wts_volume_ramp #(.NUM_CH(NUM_CH), .VOL_W(VOL_W), .RAMP_DIV(RAMP_DIV)) u_ramp (
      .clk(clk),
      .rst(reset),
      .i_reg_wr(reg_wr),
      .i_reg_ch(reg_ch),
      .i_reg_volume(reg_volume),
      .i_frame_end(w_frame_end),
      .i_rd_ch(in_ch),
      .o_rd_vol(w_vol)
   );

   // Final stage floors via arithmetic shift; the mixer closes a frame on the last channel
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r1_valid <= 1'b0;
         r1_ch <= '0;
         r1_env <= '0;
         r1_vol <= '0;
         r1_sample <= '0;
         r2_valid <= 1'b0;
         r2_ch <= '0;
         r2_sample <= '0;
         r2_gain <= '0;
         r3_valid <= 1'b0;
         r3_ch <= '0;
         r3_out <= '0;
         r_acc <= '0;
         r_mix_valid <= 1'b0;
         r_mix_out <= '0;
      end else begin
         r1_valid <= w_accept;
         r1_ch <= in_ch;
         r1_env <= in_envelope;
         r1_vol <= w_vol;
         r1_sample <= w_sample;
         r2_valid <= r1_valid;
         r2_ch <= r1_ch;
         r2_sample <= r1_sample;
         r2_gain <= GAIN_W'(r1_vol) * GAIN_W'(r1_env);
         r3_valid <= r2_valid;
         r3_ch <= r2_ch;
         r3_out <= SAMPLE_W'(w_prod >>> GAIN_W);
         r_mix_valid <= r3_valid && (r3_ch == LAST_CH);
         if (r3_valid) r_acc <= (r3_ch == LAST_CH) ? '0 : w_sat;
         if (r3_valid && r3_ch == LAST_CH) r_mix_out <= w_sat;
      end

   assign out_valid = r3_valid;
   assign out_ch = r3_ch;
   assign out_channel = r3_out;
   assign mix_valid = r_mix_valid;
   assign mix_out = r_mix_out;

endmodule

// File: tb/tb_wts_channel_volume_mix.sv
// tb_wts_channel_volume_mix: scoreboard bench driving three parameter variants with shared stimulus
module tb_wts_channel_volume_mix;
   localparam int NO = -100000;

   logic clk = 0, reset = 1, reg_wr = 0, in_valid = 0, in_noise_en = 0, in_noise = 0;
   logic [2:0] reg_ch = 0, in_ch = 0;
   logic [3:0] reg_volume = 0;
   logic signed [7:0] in_sample = 0;
   logic [4:0] in_envelope = 0;
   logic a_ov, b_ov, c_ov, a_mv, b_mv, c_mv;
   logic [2:0] a_ch, b_ch, c_ch;
   logic signed [7:0] a_out, b_out, c_out;
   logic signed [10:0] a_mo, b_mo;
   logic signed [8:0] c_mo;

   typedef struct {
      int due;
      int ch;
      int va;
      int vb;
      int vc;
   } exp_t;
   exp_t q[$];
   exp_t m;
   int cyc = 0, npass = 0, nfail = 0, ntot = 0;
   int tgt[3][5], cur[3][5], cnt[3], macc[3], mdue[3], mval[3];
   int rdiv[3] = '{1, 16, 1};
   int mw[3] = '{11, 11, 9};
   bit mon_en = 0;

   // a: fast ramp, 11-bit mix; b: 16-frame ramp; c: fast ramp, 9-bit mix
   wts_channel_volume_mix #(.RAMP_DIV(1)) ua (
      .clk(clk), .reset(reset), .reg_wr(reg_wr), .reg_ch(reg_ch), .reg_volume(reg_volume),
      .in_valid(in_valid), .in_ch(in_ch), .in_sample(in_sample), .in_envelope(in_envelope),
      .in_noise_en(in_noise_en), .in_noise(in_noise), .out_valid(a_ov), .out_ch(a_ch),
      .out_channel(a_out), .mix_valid(a_mv), .mix_out(a_mo));
   wts_channel_volume_mix #(.RAMP_DIV(16)) ub (
      .clk(clk), .reset(reset), .reg_wr(reg_wr), .reg_ch(reg_ch), .reg_volume(reg_volume),
      .in_valid(in_valid), .in_ch(in_ch), .in_sample(in_sample), .in_envelope(in_envelope),
      .in_noise_en(in_noise_en), .in_noise(in_noise), .out_valid(b_ov), .out_ch(b_ch),
      .out_channel(b_out), .mix_valid(b_mv), .mix_out(b_mo));
   wts_channel_volume_mix #(.RAMP_DIV(1), .MIX_W(9)) uc (
      .clk(clk), .reset(reset), .reg_wr(reg_wr), .reg_ch(reg_ch), .reg_volume(reg_volume),
      .in_valid(in_valid), .in_ch(in_ch), .in_sample(in_sample), .in_envelope(in_envelope),
      .in_noise_en(in_noise_en), .in_noise(in_noise), .out_valid(c_ov), .out_ch(c_ch),
      .out_channel(c_out), .mix_valid(c_mv), .mix_out(c_mo));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(string tag, int obs, int exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp(int v, int w);
      int hi = (1 << (w - 1)) - 1;
      int lo = -(1 << (w - 1));
      return v > hi ? hi : (v < lo ? lo : v);
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 3; i++) begin
         cnt[i] = 0;
         macc[i] = 0;
         mdue[i] = -1;
         mval[i] = 0;
         for (int c = 0; c < 5; c++) begin
            tgt[i][c] = 0;
            cur[i][c] = 0;
         end
      end
   endtask

   task automatic mixupd(int i, int ch, int v);
      int s = clamp(macc[i] + v, mw[i]);
      if (ch == 4) begin
         mval[i] = s;
         mdue[i] = cyc + 1;
         macc[i] = 0;
      end else macc[i] = s;
   endtask

   task automatic mixchk(int i, string n, int mv, int mo);
      chk({n, "_mix_valid"}, mv, int'(mdue[i] == cyc));
      if (mdue[i] == cyc) chk({n, "_mix_out"}, mo, mval[i]);
   endtask

   always @(negedge clk)
      if (mon_en && !reset) begin
         mixchk(0, "a", a_mv, a_mo);
         mixchk(1, "b", b_mv, b_mo);
         mixchk(2, "c", c_mv, c_mo);
         if (q.size() > 0 && q[0].due == cyc) begin
            m = q.pop_front();
            chk("a_out_valid", a_ov, 1);
            chk("b_out_valid", b_ov, 1);
            chk("c_out_valid", c_ov, 1);
            chk("a_out_ch", a_ch, m.ch);
            chk("b_out_ch", b_ch, m.ch);
            chk("c_out_ch", c_ch, m.ch);
            chk($sformatf("a_out_channel_ch%0d", m.ch), a_out, m.va);
            chk($sformatf("b_out_channel_ch%0d", m.ch), b_out, m.vb);
            chk($sformatf("c_out_channel_ch%0d", m.ch), c_out, m.vc);
            mixupd(0, m.ch, m.va);
            mixupd(1, m.ch, m.vb);
            mixupd(2, m.ch, m.vc);
         end else begin
            chk("a_out_valid_idle", a_ov, 0);
            chk("b_out_valid_idle", b_ov, 0);
            chk("c_out_valid_idle", c_ov, 0);
         end
      end

   // One clock of stimulus; expected outputs are queued here, then the volume model advances
   task automatic step(bit wr, int wch, int wvol, bit v, int ch, int smp, int env, bit ne, bit nz,
                       int xa = NO, int xb = NO, int xc = NO);
      exp_t e;
      int eff;
      @(negedge clk);
      reg_wr = wr;
      reg_ch = 3'(wch);
      reg_volume = 4'(wvol);
      in_valid = v;
      in_ch = 3'(ch);
      in_sample = 8'(smp);
      in_envelope = 5'(env);
      in_noise_en = ne;
      in_noise = nz;
      if (v && ch < 5) begin
         eff = ne ? (nz ? 127 : -127) : smp;
         e.due = cyc + 3;
         e.ch = ch;
         e.va = (xa != NO) ? xa : (eff * cur[0][ch] * env) >>> 9;
         e.vb = (xb != NO) ? xb : (eff * cur[1][ch] * env) >>> 9;
         e.vc = (xc != NO) ? xc : (eff * cur[2][ch] * env) >>> 9;
         q.push_back(e);
      end
      for (int i = 0; i < 3; i++) begin
         if (v && ch == 4) begin
            if (cnt[i] == rdiv[i] - 1) begin
               cnt[i] = 0;
               for (int c = 0; c < 5; c++)
                  cur[i][c] += (cur[i][c] < tgt[i][c]) ? 1 : (cur[i][c] > tgt[i][c]) ? -1 : 0;
            end else cnt[i]++;
         end
         if (wr && wch < 5) tgt[i][wch] = wvol;
      end
   endtask

   task automatic wr(int ch, int vol);
      step(1, ch, vol, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic sl(int ch, int smp, int env, bit ne = 0, bit nz = 0, int xa = NO, int xb = NO, int xc = NO);
      step(0, 0, 0, 1, ch, smp, env, ne, nz, xa, xb, xc);
   endtask

   task automatic idle(int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic zchk(string n, int ov, int ch, int out, int mv, int mo);
      chk({n, "_out_valid"}, ov, 0);
      chk({n, "_out_ch"}, ch, 0);
      chk({n, "_out_channel"}, out, 0);
      chk({n, "_mix_valid"}, mv, 0);
      chk({n, "_mix_out"}, mo, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #3;
      zchk("rst_a", a_ov, a_ch, a_out, a_mv, a_mo);
      zchk("rst_b", b_ov, b_ch, b_out, b_mv, b_mo);
      zchk("rst_c", c_ov, c_ch, c_out, c_mv, c_mo);
      @(negedge clk);
      reset = 0;
      mon_en = 1;
      wr(0, 15);
      wr(1, 4);
      wr(2, 15);
      wr(3, 15);
      wr(4, 15);
      // Ramp: a/c step every frame, b every 16th; write on ch1 lands with b's third step
      for (int f = 0; f < 49; f++) begin
         sl(0, 127, 31, 0, 0, f == 15 ? 115 : NO, NO, f == 15 ? 115 : NO);
         sl(1, 127, 31, 0, 0, f == 48 ? 30 : NO, f == 15 ? 0 : f == 16 ? 7 : f == 48 ? 23 : NO,
            f == 48 ? 30 : NO);
         step(f == 47, 1, 0, 1, 4, 0, 0, 0, 0);
      end
      sl(2, -128, 31, 0, 0, -117, NO, -117);
      sl(2, 0, 31, 1, 1, 115, NO, 115);
      sl(2, 0, 31, 1, 0, -116, NO, -116);
      sl(2, 0, 0, 1, 1, 0, 0, 0);
      step(1, 7, 9, 1, 6, 100, 31, 0, 0);
      step(1, 5, 9, 1, 5, 100, 31, 0, 0);
      wr(1, 15);
      repeat (12) sl(4, 0, 0);
      for (int c = 0; c < 5; c++) sl(c, 127, 31, 0, 0, 115, NO, 115);
      idle(6);
      chk("a_full_frame_mix", a_mo, 575);
      chk("c_full_frame_mix_sat", c_mo, 255);
      // Reset lands with ch0 already accumulated and ch1 on the output
      sl(0, 127, 31);
      sl(1, 127, 31);
      idle(3);
      #2 reset = 1;
      #1;
      zchk("midrst_a", a_ov, a_ch, a_out, a_mv, a_mo);
      zchk("midrst_b", b_ov, b_ch, b_out, b_mv, b_mo);
      zchk("midrst_c", c_ov, c_ch, c_out, c_mv, c_mo);
      model_reset();
      @(negedge clk);
      reset = 0;
      sl(4, 127, 31);
      idle(4);
      wr(4, 15);
      repeat (3) sl(4, 127, 31);
      idle(6);
      chk("scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
